// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, branch/jump flushes.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int REGW     = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] rs_d,
    input  logic [REGW-1:0] rt_d,
    input  logic [REGW-1:0] rt_e,
    input  logic            memtoreg_e,
    input  logic            branch_taken_d,
    input  logic            jump_d,
    input  logic            md_start_e,
    input  logic            md_op_e,
    input  logic            md_use_d,
    output logic            stall_f,
    output logic            stall_d,
    output logic            flush_d,
    output logic            flush_e,
    output logic            md_busy,
    output logic            md_done,
    output logic [31:0]     perf_stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    localparam logic [7:0] MULT_LOAD = 8'(MULT_LAT - 1);
    localparam logic [7:0] DIV_LOAD  = 8'(DIV_LAT - 1);

    md_state_e  state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       done_q, done_d;
    logic       lwstall, mdstall, hazard_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // A start arriving while BUSY is ignored; mdstall keeps it from happening.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (md_start_e) begin
                    cnt_d   = md_op_e ? DIV_LOAD : MULT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign lwstall = memtoreg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));
    assign mdstall = md_use_d && ((state_q == BUSY) || md_start_e);

    // All outputs read 0 while reset is held, including the combinational ones.
    assign hazard_stall = (lwstall || mdstall) && !reset;

    assign stall_f = hazard_stall;
    assign stall_d = hazard_stall;
    assign flush_e = hazard_stall;
    assign flush_d = (branch_taken_d || jump_d) && !hazard_stall && !reset;
    assign md_busy = (state_q == BUSY);
    assign md_done = done_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= 32'd0;
        end else if (hazard_stall && (perf_q != 32'hFFFF_FFFF)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a reference model pushes expected
// output vectors as stimulus is driven; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int REGW     = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [REGW-1:0] rs_d = '0, rt_d = '0, rt_e = '0;
    logic            memtoreg_e = 1'b0, branch_taken_d = 1'b0, jump_d = 1'b0;
    logic            md_start_e = 1'b0, md_op_e = 1'b0, md_use_d = 1'b0;
    logic            stall_f, stall_d, flush_d, flush_e, md_busy, md_done;
    logic [31:0]     perf_stall_cnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [5:0] exp;
    } exp_t;

    exp_t q[$];

    // reference model state
    int          m_left  = 0;
    bit          m_done  = 1'b0;
    bit          m_stall = 1'b0;
    logic [31:0] m_perf  = 32'd0;

    pipe_hazard_ctrl #(
        .MULT_LAT(MULT_LAT),
        .DIV_LAT (DIV_LAT),
        .REGW    (REGW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rs_d          (rs_d),
        .rt_d          (rt_d),
        .rt_e          (rt_e),
        .memtoreg_e    (memtoreg_e),
        .branch_taken_d(branch_taken_d),
        .jump_d        (jump_d),
        .md_start_e    (md_start_e),
        .md_op_e       (md_op_e),
        .md_use_d      (md_use_d),
        .stall_f       (stall_f),
        .stall_d       (stall_d),
        .flush_d       (flush_d),
        .flush_e       (flush_e),
        .md_busy       (md_busy),
        .md_done       (md_done),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit rst_v, input logic [REGW-1:0] rs_v, rt_v, rte_v,
                        input bit mem_v, br_v, jmp_v, st_v, op_v, use_v, input string tag);
        bit   lw, busy, stall, fd;
        exp_t e;
        @(posedge clk);
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_perf = 32'd0;
        end else begin
            if (m_stall && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
            m_done = (m_left == 1);
            if (m_left > 0) m_left = m_left - 1;
            else if (md_start_e) m_left = md_op_e ? DIV_LAT : MULT_LAT;
        end
        #1;
        reset          = rst_v;
        rs_d           = rs_v;
        rt_d           = rt_v;
        rt_e           = rte_v;
        memtoreg_e     = mem_v;
        branch_taken_d = br_v;
        jump_d         = jmp_v;
        md_start_e     = st_v;
        md_op_e        = op_v;
        md_use_d       = use_v;
        if (rst_v) begin
            m_left = 0;
            m_done = 1'b0;
            m_perf = 32'd0;
        end
        lw      = mem_v && (rte_v != 0) && (rte_v == rs_v || rte_v == rt_v);
        busy    = (m_left > 0);
        stall   = (lw || (use_v && (busy || st_v))) && !rst_v;
        fd      = (br_v || jmp_v) && !stall && !rst_v;
        m_stall = stall;
        e.tag   = tag;
        e.exp   = {stall, stall, fd, stall, busy && !rst_v, m_done && !rst_v};
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.tag, {26'd0, stall_f, stall_d, flush_d, flush_e, md_busy, md_done}, {26'd0, e.exp});
        end
    end

    logic [31:0] exp_perf;

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, "reset");
        step(1, 8, 0, 8, 1, 1, 0, 1, 0, 1, "reset_hold");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
        // load-use
        step(0, 8, 3, 8, 1, 0, 0, 0, 0, 0, "lw_rs");
        step(0, 8, 3, 8, 1, 0, 0, 0, 0, 0, "lw_rs2");
        step(0, 4, 9, 9, 1, 0, 0, 0, 0, 0, "lw_rt");
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, "lw_r0");
        step(0, 8, 8, 8, 0, 0, 0, 0, 0, 0, "no_load");
        // branch / jump flush with stall priority
        step(0, 1, 2, 3, 0, 1, 0, 0, 0, 0, "br_flush");
        step(0, 8, 2, 8, 1, 1, 0, 0, 0, 0, "br_held");
        step(0, 8, 2, 8, 1, 1, 0, 0, 0, 0, "br_held2");
        step(0, 8, 2, 8, 0, 1, 0, 0, 0, 0, "br_release");
        step(0, 1, 2, 3, 0, 0, 1, 0, 0, 0, "jump_flush");
        // multiply with dependent reader held in ID
        for (int i = 0; i < 8; i++) step(0, 1, 2, 3, 0, 0, 0, i == 0, 0, 1, "mult");
        // ignored start while busy
        for (int i = 0; i < 8; i++) step(0, 1, 2, 3, 0, 0, 0, i == 0 || i == 2, 0, 0, "mult_ign");
        // divide abandoned by reset at T+4, then a normal multiply
        for (int i = 0; i < 4; i++) step(0, 1, 2, 3, 0, 0, 0, i == 0, 1, 1, "div");
        step(1, 1, 2, 3, 0, 0, 0, 0, 0, 1, "div_rst");
        for (int i = 0; i < 8; i++) step(0, 1, 2, 3, 0, 0, 0, i == 0, 0, 1, "post_rst");
        // 3 load-use + 5 mult stall cycles from a cleared perf counter
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, "perf_rst");
        for (int i = 0; i < 3; i++) step(0, 7, 0, 7, 1, 0, 0, 0, 0, 0, "perf_lw");
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "perf_start");
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "perf_mult");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "perf_idle");
`ifdef HAZARD_PERF_EN
        exp_perf = m_perf;
        chk("perf_8", m_perf, 32'd8);
`else
        exp_perf = 32'd0;
`endif
        chk("perf_cnt", perf_stall_cnt, exp_perf);
        // random mix
        for (int i = 0; i < 60; i++)
            step(0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
                 bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), "rand");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "tail");
`ifdef HAZARD_PERF_EN
        exp_perf = m_perf;
`else
        exp_perf = 32'd0;
`endif
        chk("perf_rand", perf_stall_cnt, exp_perf);
        @(negedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline registers that expose `reset`, `clear` and enable controls.
- Generates the per-stage stall (enable-low) and clear (flush) controls for the IF/ID and ID/EX registers and for the PC.
- Detects load-use hazards and taken branches/jumps.
- Sequences a multi-cycle multiply/divide unit through a busy counter, holding dependent HI/LO readers in ID until the result is ready.

Parameters:
MULT_LAT, 5, multiply latency in cycles (1..255)
DIV_LAT, 10, divide latency in cycles (1..255)
REGW, 5, register-number width

Ports:
clk  in  1  pipeline clock, all state on rising edge
reset  in  1  asynchronous active-high reset
rs_d  in  REGW  source register rs of instruction in ID
rt_d  in  REGW  source register rt of instruction in ID
rt_e  in  REGW  destination rt of instruction in EX
memtoreg_e  in  1  EX instruction is a load
branch_taken_d  in  1  branch resolved taken in ID
jump_d  in  1  jump in ID
md_start_e  in  1  EX instruction starts mult/div
md_op_e  in  1  0 = mult, 1 = div (valid with md_start_e)
md_use_d  in  1  ID instruction reads HI/LO or starts mult/div
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID register
flush_d  out  1  clear IF/ID register
flush_e  out  1  clear ID/EX register
md_busy  out  1  mult/div unit occupied
md_done  out  1  one-cycle pulse: result written to HI/LO
perf_stall_cnt  out  32  stall cycle count (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-high: asserting `reset` immediately forces the FSM to IDLE, the counter to 0, md_done to 0 and perf_stall_cnt to 0. While reset is high, all outputs are 0.
- Load-use stall (combinational):
  - lwstall = memtoreg_e & (rt_e != 0) & ((rt_e == rs_d) | (rt_e == rt_d)).
  - Register 0 never stalls.
- Mult/div FSM, 8-bit down-counter cnt, states IDLE and BUSY:
  - IDLE and md_start_e at edge T: cnt <= (md_op_e ? DIV_LAT : MULT_LAT) - 1; state <= BUSY.
  - BUSY and cnt != 0: cnt <= cnt - 1.
  - BUSY and cnt == 0: state <= IDLE; md_done <= 1 for exactly one cycle.
  - Net timing: md_busy is high for exactly LAT cycles starting at T+1. md_done is high in the first IDLE cycle.
  - md_start_e while BUSY is ignored. It cannot occur legally because of mdstall.
  - md_busy = (state == BUSY).
- Mult/div stall (combinational): mdstall = md_use_d & (md_busy | md_start_e).
- Outputs:
  - stall_f = stall_d = lwstall | mdstall.
  - flush_e = lwstall | mdstall (inserts a bubble into EX while ID is held).
  - flush_d = (branch_taken_d | jump_d) & ~stall_d. Stall has priority over flush, so a held branch is not squashed until its stall releases.
- Simultaneous events:
  - lwstall and mdstall together produce a single stall. The mult/div counter keeps running during any stall.
  - md_done coincides with the release of mdstall. The ID instruction proceeds in that same cycle.
- Reset mid-operation abandons the mult/div op. md_done does not pulse for it.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined: perf_stall_cnt increments by 1 on every rising edge where stall_d is 1 and reset is 0. It saturates at 32'hFFFF_FFFF.
- Undefined: perf_stall_cnt is tied to 0 and the counter logic is absent.

Test Plan:
- Load-use: memtoreg_e=1, rt_e=8, rs_d=8 → stall_f=stall_d=flush_e=1 that cycle; with rt_e=0 and rs_d=0 → all 0.
- Branch: branch_taken_d=1, no stall → flush_d=1, flush_e=0. Repeat with lwstall active → flush_d=0 until the stall drops, then flush_d=1.
- Multiply: md_start_e=1, md_op_e=0 at edge T → md_busy high T+1..T+5, md_done pulse at T+6. md_use_d=1 throughout → stall_d high through T+5, low at T+6.
- Divide reset: md_op_e=1 start, assert reset at T+4 → md_busy=0 immediately, no md_done; after release, an IDLE start behaves normally.
- Ignored start: md_start_e pulsed at T+2 while BUSY (mult started at T) → completion still at T+6, no extended busy.
- Perf (HAZARD_PERF_EN defined): 3 load-use stall cycles + 5 mult stall cycles → perf_stall_cnt=8. Macro undefined → perf_stall_cnt=0.
